// File: rtl/sys_ctrl.sv
// Byte-framed register-file controller behind a UART: 0xAA,ADDR,DATA writes; 0xBB,ADDR reads and replies.
// Optional macro SYS_CTRL_WR_ACK_EN makes every committed write reply with an 0x55 acknowledge byte.
module sys_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic             TX_BUSY,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             CMD_ERR,
    output logic [2:0]       o_dbg_state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [WIDTH-1:0] OP_WR  = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] OP_RD  = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0] ACK    = WIDTH'(8'h55);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        TX_SEND = 3'd4,
        TX_WAIT = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      r_regs [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      r_cnt;
    logic [WIDTH-1:0]      r_tx_data;
    logic                  r_cmd_err;

    logic                  w_err;
    logic                  w_wr_en;
    logic                  w_addr_latch;
    logic                  w_tx_load;
    logic [WIDTH-1:0]      w_tx_val;
    logic                  w_tx_vld;
    logic                  w_in_frame;
    logic                  w_timeout;
    logic                  w_addr_ok;
    logic [ADDR_WIDTH-1:0] w_rx_addr;

    assign w_rx_addr = RX_P_DATA[ADDR_WIDTH-1:0];
    assign w_addr_ok = ((RX_P_DATA >> ADDR_WIDTH) == '0);
    assign w_timeout = (r_cnt == TO_VAL);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A byte always takes priority over a timeout that expires on the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_err        = 1'b0;
        w_wr_en      = 1'b0;
        w_addr_latch = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_val     = '0;
        w_tx_vld     = 1'b0;
        w_in_frame   = 1'b0;
        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == OP_WR) begin
                        w_state_nxt = WR_ADDR;
                    end else if (RX_P_DATA == OP_RD) begin
                        w_state_nxt = RD_ADDR;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                w_in_frame = 1'b1;
                if (RX_D_VLD) begin
                    if (w_addr_ok) begin
                        w_addr_latch = 1'b1;
                        w_state_nxt  = WR_DATA;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WR_DATA: begin
                w_in_frame = 1'b1;
                if (RX_D_VLD) begin
                    w_wr_en = 1'b1;
`ifdef SYS_CTRL_WR_ACK_EN
                    w_tx_load   = 1'b1;
                    w_tx_val    = ACK;
                    w_state_nxt = TX_SEND;
`else
                    w_state_nxt = IDLE;
`endif
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            RD_ADDR: begin
                w_in_frame = 1'b1;
                if (RX_D_VLD) begin
                    if (w_addr_ok) begin
                        w_addr_latch = 1'b1;
                        w_tx_load    = 1'b1;
                        w_tx_val     = r_regs[w_rx_addr];
                        w_state_nxt  = TX_SEND;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            TX_SEND: begin
                w_err = RX_D_VLD;
                if (!TX_BUSY) begin
                    w_tx_vld    = 1'b1;
                    w_state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                w_err = RX_D_VLD;
                if (TX_BUSY) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_tx_data <= '0;
            r_cmd_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // Back-to-back errors collapse so the flag never stays high two cycles.
            r_cmd_err <= w_err & ~r_cmd_err;
            if (w_in_frame && !RX_D_VLD && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_addr_latch) begin
                r_addr <= w_rx_addr;
            end
            if (w_wr_en) begin
                r_regs[r_addr] <= RX_P_DATA;
            end
            if (w_tx_load) begin
                r_tx_data <= w_tx_val;
            end
        end
    end

    assign TX_P_DATA   = r_tx_data;
    assign TX_D_VLD    = w_tx_vld;
    assign CMD_ERR     = r_cmd_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: frame decode, read/write, backpressure, timeout, reset, optional write ack.
// Define SYS_CTRL_WR_ACK_EN for both bench and RTL to exercise the acknowledge build.
module tb_sys_ctrl;

    localparam int TIMEOUT = 1024;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_TX_SEND = 3'd4;
    localparam logic [2:0] ST_TX_WAIT = 3'd5;

    logic       CLK;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       TX_BUSY;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       CMD_ERR;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int n_tx     = 0;
    int n_err    = 0;
    int consec   = 0;
    logic prev_tx  = 1'b0;
    logic prev_err = 1'b0;

    sys_ctrl #(.WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .TX_BUSY    (TX_BUSY),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .CMD_ERR    (CMD_ERR),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // pulse counters, sampled on the falling edge
    always @(negedge CLK) begin
        if (RST) begin
            if (TX_D_VLD) n_tx <= n_tx + 1;
            if (CMD_ERR)  n_err <= n_err + 1;
            if ((TX_D_VLD && prev_tx) || (CMD_ERR && prev_err)) consec <= consec + 1;
        end
        prev_tx  <= TX_D_VLD;
        prev_err <= CMD_ERR;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'hEE;
    endtask

    task automatic finish_tx();
        TX_BUSY = 1'b1;
        repeat (3) tick();
        TX_BUSY = 1'b0;
        tick();
        check("idle_after_tx", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
`ifdef SYS_CTRL_WR_ACK_EN
        check("ack_vld", {31'd0, TX_D_VLD}, 32'd1);
        check("ack_data", {24'd0, TX_P_DATA}, 32'h55);
        tick();
        check("ack_one_cycle", {31'd0, TX_D_VLD}, 32'd0);
        finish_tx();
`else
        check("wr_no_rsp", {31'd0, TX_D_VLD}, 32'd0);
        check("wr_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
`endif
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
        TX_BUSY = 1'b0;
        send_byte(8'hBB);
        send_byte(a);
        check($sformatf("rd_vld_%0h", a), {31'd0, TX_D_VLD}, 32'd1);
        check($sformatf("rd_data_%0h", a), {24'd0, TX_P_DATA}, {24'd0, exp});
        tick();
        check($sformatf("rd_one_cycle_%0h", a), {31'd0, TX_D_VLD}, 32'd0);
        finish_tx();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_txd"}, {24'd0, TX_P_DATA}, 32'd0);
        check({tag, "_txv"}, {31'd0, TX_D_VLD}, 32'd0);
        check({tag, "_err"}, {31'd0, CMD_ERR}, 32'd0);
        check({tag, "_st"}, {29'd0, dbg_state}, {29'd0, ST_IDLE});
    endtask

    initial begin
        int e0;
        int t0;
        int i;
        RST       = 1'b0;
        RX_P_DATA = 8'h00;
        RX_D_VLD  = 1'b0;
        TX_BUSY   = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        RST = 1'b1;
        tick();

        // write then read
        do_write(8'h03, 8'h5C);
        do_read(8'h03, 8'h5C);

        do_write(8'h00, 8'hA5);
        do_write(8'h0F, 8'h3C);
        do_read(8'h00, 8'hA5);
        do_read(8'h0F, 8'h3C);
        do_read(8'h07, 8'h00);
        do_read(8'h03, 8'h5C);

        // bad opcode and address
        e0 = n_err;
        send_byte(8'h12);
        check("badop_err", {31'd0, CMD_ERR}, 32'd1);
        check("badop_st", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        tick();
        check("badop_pulse", {31'd0, CMD_ERR}, 32'd0);
        check("badop_count", n_err - e0, 32'd1);

        e0 = n_err;
        t0 = n_tx;
        send_byte(8'hBB);
        send_byte(8'h10);
        check("badaddr_err", {31'd0, CMD_ERR}, 32'd1);
        check("badaddr_txv", {31'd0, TX_D_VLD}, 32'd0);
        check("badaddr_st", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        repeat (3) tick();
        check("badaddr_no_tx", n_tx - t0, 32'd0);
        check("badaddr_count", n_err - e0, 32'd1);

        send_byte(8'hAA);
        send_byte(8'h1F);
        check("badwaddr_err", {31'd0, CMD_ERR}, 32'd1);
        check("badwaddr_st", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        tick();
        do_read(8'h0F, 8'h3C);

        // busy backpressure
        TX_BUSY = 1'b1;
        repeat (20) tick();
        send_byte(8'hBB);
        send_byte(8'h03);
        check("bp_hold_st", {29'd0, dbg_state}, {29'd0, ST_TX_SEND});
        for (int k = 0; k < 4; k++) begin
            check("bp_no_vld", {31'd0, TX_D_VLD}, 32'd0);
            check("bp_data_stable", {24'd0, TX_P_DATA}, 32'h5C);
            tick();
        end
        send_byte(8'hAA);
        check("bp_drop_err", {31'd0, CMD_ERR}, 32'd1);
        check("bp_drop_st", {29'd0, dbg_state}, {29'd0, ST_TX_SEND});
        TX_BUSY = 1'b0;
        #1;
        check("bp_vld", {31'd0, TX_D_VLD}, 32'd1);
        check("bp_data", {24'd0, TX_P_DATA}, 32'h5C);
        tick();
        check("bp_one_cycle", {31'd0, TX_D_VLD}, 32'd0);
        check("bp_wait_st", {29'd0, dbg_state}, {29'd0, ST_TX_WAIT});
        check("bp_wait_data", {24'd0, TX_P_DATA}, 32'h5C);
        finish_tx();

        // timeout abandons a partial write
        e0 = n_err;
        send_byte(8'hAA);
        send_byte(8'h02);
        i = 0;
        while (!CMD_ERR && i < TIMEOUT + 20) begin
            tick();
            i++;
        end
        check("to_seen", {31'd0, CMD_ERR}, 32'd1);
        check("to_not_early", (i >= TIMEOUT) ? 32'd1 : 32'd0, 32'd1);
        check("to_not_late", (i <= TIMEOUT + 1) ? 32'd1 : 32'd0, 32'd1);
        check("to_st", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        tick();
        check("to_count", n_err - e0, 32'd1);
        do_read(8'h02, 8'h00);

        // a byte on the expiry cycle wins over the timeout
        e0 = n_err;
        send_byte(8'hAA);
        repeat (TIMEOUT) tick();
        send_byte(8'h04);
        check("tie_st", {29'd0, dbg_state}, {29'd0, ST_WR_DATA});
        check("tie_no_err", {31'd0, CMD_ERR}, 32'd0);
        send_byte(8'h4D);
`ifdef SYS_CTRL_WR_ACK_EN
        tick();
        finish_tx();
`endif
        check("tie_err_count", n_err - e0, 32'd0);
        do_read(8'h04, 8'h4D);

        // reset mid-frame
        send_byte(8'hAA);
        send_byte(8'h01);
        RST = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        tick();
        RST = 1'b1;
        tick();
        check_outputs_zero("rst_rel");
        send_byte(8'h77);
        check("rst_77_err", {31'd0, CMD_ERR}, 32'd1);
        tick();
        do_read(8'h01, 8'h00);
        do_read(8'h03, 8'h00);

        // reset with a response pending
        TX_BUSY = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h04);
        check("rst_pend_st", {29'd0, dbg_state}, {29'd0, ST_TX_SEND});
        RST = 1'b0;
        #1;
        check("rst_pend_txv", {31'd0, TX_D_VLD}, 32'd0);
        check("rst_pend_txd", {24'd0, TX_P_DATA}, 32'd0);
        tick();
        TX_BUSY = 1'b0;
        RST = 1'b1;
        t0 = n_tx;
        repeat (3) tick();
        check("rst_pend_no_tx", n_tx - t0, 32'd0);
        check("rst_pend_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});

        // write response count (ack only in the ack build)
        t0 = n_tx;
        do_write(8'h00, 8'hFF);
`ifdef SYS_CTRL_WR_ACK_EN
        check("wr_tx_count", n_tx - t0, 32'd1);
`else
        check("wr_tx_count", n_tx - t0, 32'd0);
`endif
        do_read(8'h00, 8'hFF);

        tick();
        check("no_consecutive_pulses", consec, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
